rom_stream_loader: RTL and testbench
====================================

Name: rom_stream_loader

Overview:
- Hardware program loader: receives a byte stream from the UART debug path, packs bytes little-endian into 32-bit words and writes them into the instruction ROM.
- Holds the core in reset while loading; releases it only after a correct checksum.
- Sits between the UART receiver and the ROM write port inside the SoC top.

Parameters:
ROM_ADDR_WIDTH, 14, ROM byte-address width; word depth = 1<<(ROM_ADDR_WIDTH-2), byte capacity = depth*4.
BOOT_HOLD, 1, 1: hold_core_o resets to 1 and stays high until first successful load; 0: hold_core_o resets to 0 and is high only while a load is in progress or has failed.

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
start_i  input  1  one-cycle pulse; begins (or restarts) a load
byte_valid_i  input  1  stream byte valid
byte_data_i  input  8  stream byte
byte_ready_o  output  1  loader accepts byte this cycle (transfer = valid & ready)
rom_we_o  output  1  ROM word write strobe, one cycle per word
rom_addr_o  output  ROM_ADDR_WIDTH-2  ROM word address
rom_wdata_o  output  32  ROM write data
hold_core_o  output  1  keep core in reset
busy_o  output  1  load in progress
done_o  output  1  last load succeeded (sticky until next start_i)
err_o  output  1  last load failed (sticky until next start_i)
words_o  output  ROM_ADDR_WIDTH-1  words written by current/last load

Behaviour:
- Reset values: byte_ready_o=0, rom_we_o=0, rom_addr_o=0, rom_wdata_o=0, busy_o=0, done_o=0, err_o=0, words_o=0, hold_core_o=BOOT_HOLD; state IDLE.
- Frame: 4-byte length L (little-endian, byte count) | L payload bytes | 1 checksum byte = sum of payload bytes mod 256.
- States: IDLE, LEN, DATA, FLUSH, CSUM, DONE, ERR.
- IDLE/DONE/ERR: byte_ready_o=0. On start_i, next state is LEN. Clears done_o, err_o, words_o, word pointer, checksum accumulator and byte counters. Sets busy_o=1 and hold_core_o=1.
- start_i in any other state: abort and restart identically. A partially assembled word is discarded; already-written words are not undone.
- LEN: byte_ready_o=1. Accepts 4 bytes, L[7:0] first. After 4th byte:
  - L > ROM byte capacity -> ERR.
  - L==0 -> CSUM.
  - Otherwise -> DATA.
- DATA: byte_ready_o=1. Each byte goes into lane (count mod 4) and is added to the checksum (8-bit wrap).
  - When 4th lane filled: the cycle after, rom_we_o=1, rom_addr_o=word pointer, rom_wdata_o={b3,b2,b1,b0}. Word pointer and words_o then increment.
  - No stall: accepting a byte in the write cycle is legal.
- After payload byte L is accepted:
  - L mod 4 == 0: the final word write occurs next cycle as above; state -> CSUM.
  - L mod 4 != 0: state -> FLUSH, byte_ready_o=0. Next cycle writes the padded word with unfilled upper lanes = 0x00, then -> CSUM.
- CSUM: byte_ready_o=1. Accept one byte.
  - Equal to accumulator -> DONE: done_o=1, busy_o=0, hold_core_o=0.
  - Not equal -> ERR.
- ERR: err_o=1, busy_o=0, hold_core_o=1 regardless of BOOT_HOLD.
- Latency: last payload byte to final rom_we_o = 1 cycle (aligned) or 2 cycles (FLUSH). Checksum byte accept to done_o/err_o = 1 cycle.
- Word pointer never wraps: the length check guarantees at most depth words.
- rom_addr_o/rom_wdata_o hold last values when rom_we_o=0.
- byte_valid_i while byte_ready_o=0: byte is ignored, not consumed.
- Async rst mid-load: all outputs return to reset values immediately; ROM contents are untouched.

Test Plan:
- Aligned load: start_i, L=8 (08 00 00 00), bytes 13 00 00 00 6F 00 00 00, csum 0x82 -> writes addr0=0x00000013, addr1=0x0000006F; done_o=1, hold_core_o=0, words_o=2.
- Unaligned load: L=5, bytes 01 02 03 04 05, csum 0x0F -> addr0=0x04030201, addr1=0x00000005 (written via FLUSH); done_o=1.
- Bad checksum: L=4, bytes AA BB CC DD, csum 0x00 (expected 0x0E) -> word written, err_o=1, done_o=0, hold_core_o=1.
- Oversize: ROM_ADDR_WIDTH=6 (64 B), L=65 -> ERR after 4th length byte, no rom_we_o pulses, byte_ready_o=0.
- Restart and L=0: start_i mid-DATA, then L=0 with csum 0x00 -> done_o=1, words_o=0, no writes. Then a new start_i clears done_o.
- Backpressure/reset: byte_valid_i toggled randomly gives identical ROM image. rst asserted mid-DATA -> busy_o=0, hold_core_o=BOOT_HOLD, done_o=err_o=0 immediately.

Source files
------------

// File: rtl/rom_stream_loader.sv
// rom_stream_loader: unpacks a length-prefixed, checksummed byte stream into 32-bit ROM words.
// Holds the core in reset until a load completes with a matching checksum.
module rom_stream_loader #(
    parameter int ROM_ADDR_WIDTH = 14,
    parameter bit BOOT_HOLD      = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic                      byte_valid_i,
    input  logic [7:0]                byte_data_i,
    output logic                      byte_ready_o,
    output logic                      rom_we_o,
    output logic [ROM_ADDR_WIDTH-3:0] rom_addr_o,
    output logic [31:0]               rom_wdata_o,
    output logic                      hold_core_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic [ROM_ADDR_WIDTH-2:0] words_o
);
    localparam logic [32:0] CAP = 33'(1) << ROM_ADDR_WIDTH;

    typedef enum logic [2:0] {IDLE, LEN, DATA, FLUSH, CSUM, DONE, ERR} state_t;

    state_t                    state_q, state_d;
    logic [1:0]                lcnt_q, lcnt_d;
    logic [31:0]               len_q, len_d;
    logic [ROM_ADDR_WIDTH:0]   pcnt_q, pcnt_d;
    logic [31:0]               word_q, word_d;
    logic [7:0]                csum_q, csum_d;
    logic [ROM_ADDR_WIDTH-3:0] wptr_q, wptr_d;
    logic [ROM_ADDR_WIDTH-2:0] words_q, words_d;
    logic                      we_q, we_d;
    logic [ROM_ADDR_WIDTH-3:0] addr_q, addr_d;
    logic [31:0]               wdata_q, wdata_d;
    logic                      busy_q, busy_d, done_q, done_d, err_q, err_d, hold_q, hold_d;
    logic                      xfer, last;
    logic [31:0]               len_full, word_nx;

    assign byte_ready_o = state_q inside {LEN, DATA, CSUM};
    assign xfer         = byte_valid_i & byte_ready_o;
    assign len_full     = {byte_data_i, len_q[23:0]};
    assign last         = (32'(pcnt_q) + 32'd1) == len_q;

    always_comb begin
        word_nx = word_q;
        word_nx[{pcnt_q[1:0], 3'b000} +: 8] = byte_data_i;
    end

    always_comb begin
        state_d = state_q;
        lcnt_d  = lcnt_q;
        len_d   = len_q;
        pcnt_d  = pcnt_q;
        word_d  = word_q;
        csum_d  = csum_q;
        wptr_d  = wptr_q;
        words_d = words_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        hold_d  = hold_q;
        case (state_q)
            LEN: if (xfer) begin
                len_d[{lcnt_q, 3'b000} +: 8] = byte_data_i;
                lcnt_d = lcnt_q + 2'd1;
                if (lcnt_q == 2'd3) begin
                    state_d = ({1'b0, len_full} > CAP) ? ERR : (len_full == 32'd0) ? CSUM : DATA;
                    if ({1'b0, len_full} > CAP) begin
                        err_d  = 1'b1;
                        busy_d = 1'b0;
                    end
                end
            end
            DATA: if (xfer) begin
                csum_d = csum_q + byte_data_i;
                pcnt_d = pcnt_q + 1'b1;
                word_d = word_nx;
                if (pcnt_q[1:0] == 2'd3) begin
                    we_d    = 1'b1;
                    addr_d  = wptr_q;
                    wdata_d = word_nx;
                    wptr_d  = wptr_q + 1'b1;
                    words_d = words_q + 1'b1;
                    word_d  = 32'd0;
                end
                if (last) state_d = (pcnt_q[1:0] == 2'd3) ? CSUM : FLUSH;
            end
            // upper lanes of the partial word are still zero from the last clear
            FLUSH: begin
                we_d    = 1'b1;
                addr_d  = wptr_q;
                wdata_d = word_q;
                wptr_d  = wptr_q + 1'b1;
                words_d = words_q + 1'b1;
                word_d  = 32'd0;
                state_d = CSUM;
            end
            CSUM: if (xfer) begin
                state_d = (byte_data_i == csum_q) ? DONE : ERR;
                done_d  = byte_data_i == csum_q;
                err_d   = byte_data_i != csum_q;
                hold_d  = byte_data_i != csum_q;
                busy_d  = 1'b0;
            end
            default: ;
        endcase
        if (start_i) begin
            state_d = LEN;
            lcnt_d  = 2'd0;
            len_d   = 32'd0;
            pcnt_d  = '0;
            word_d  = 32'd0;
            csum_d  = 8'd0;
            wptr_d  = '0;
            words_d = '0;
            we_d    = 1'b0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            err_d   = 1'b0;
            hold_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lcnt_q  <= 2'd0;
            len_q   <= 32'd0;
            pcnt_q  <= '0;
            word_q  <= 32'd0;
            csum_q  <= 8'd0;
            wptr_q  <= '0;
            words_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= BOOT_HOLD;
        end else begin
            state_q <= state_d;
            lcnt_q  <= lcnt_d;
            len_q   <= len_d;
            pcnt_q  <= pcnt_d;
            word_q  <= word_d;
            csum_q  <= csum_d;
            wptr_q  <= wptr_d;
            words_q <= words_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
        end
    end

    assign rom_we_o    = we_q;
    assign rom_addr_o  = addr_q;
    assign rom_wdata_o = wdata_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign hold_core_o = hold_q;
    assign words_o     = words_q;
endmodule

// File: tb/tb_rom_stream_loader.sv
// tb_rom_stream_loader: frame vectors plus corner sequences on a 64-byte ROM instance;
// expected ROM writes are queued when a frame is driven and matched as the DUT emits them.
module tb_rom_stream_loader;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst, start, byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready, rom_we, hold_core, busy, done, err;
    logic [AW-3:0] rom_addr;
    logic [31:0]   rom_wdata;
    logic [AW-2:0] words;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q [$];

    typedef struct {
        int          len;
        logic [63:0] pl;
        logic [7:0]  cs;
        bit          ok;
        int          nwords;
    } vec_t;

    vec_t vecs [6];

    rom_stream_loader #(.ROM_ADDR_WIDTH(AW), .BOOT_HOLD(1'b1)) dut (
        .clk(clk), .rst(rst), .start_i(start), .byte_valid_i(byte_valid),
        .byte_data_i(byte_data), .byte_ready_o(byte_ready), .rom_we_o(rom_we),
        .rom_addr_o(rom_addr), .rom_wdata_o(rom_wdata), .hold_core_o(hold_core),
        .busy_o(busy), .done_o(done), .err_o(err), .words_o(words)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rom_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr %0h data %h", rom_addr, rom_wdata);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({32'(rom_addr), rom_wdata} !== e) begin
                    errors++;
                    $display("FAIL rom_write: got %h expected %h", {32'(rom_addr), rom_wdata}, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int n = 0;
        if (rnd) repeat ($urandom_range(0, 2)) tick();
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && n < 50) begin
            tick();
            n++;
        end
        if (!byte_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: byte %h never accepted", b);
        end
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic send_len(input logic [31:0] l);
        for (int k = 0; k < 4; k++) send_byte(l[8*k +: 8], 1'b0);
    endtask

    function automatic logic [7:0] pb(input vec_t v, input int i);
        if (i < 8) return v.pl[8*i +: 8];
        return 8'(i * 7 + 3);
    endfunction

    task automatic run_vec(input vec_t v, input bit rnd);
        logic [31:0] w;
        logic [31:0] l;
        w = 32'd0;
        l = v.len;
        for (int i = 0; i < v.len; i++) begin
            w[8*(i%4) +: 8] = pb(v, i);
            if (i % 4 == 3 || i == v.len - 1) begin
                exp_q.push_back({32'(i / 4), w});
                w = 32'd0;
            end
        end
        pulse_start();
        chk("start_busy", busy, 1);
        chk("start_done_clr", done, 0);
        chk("start_hold", hold_core, 1);
        for (int k = 0; k < 4; k++) send_byte(l[8*k +: 8], rnd);
        for (int i = 0; i < v.len; i++) begin
            send_byte(pb(v, i), rnd);
            if (i == v.len - 1) begin
                chk("last_we_latency", rom_we, (v.len % 4) == 0);
                chk("last_ready", byte_ready, (v.len % 4) == 0);
            end
        end
        send_byte(v.cs, rnd);
        chk("done", done, v.ok);
        chk("err", err, !v.ok);
        chk("hold", hold_core, !v.ok);
        chk("busy_end", busy, 0);
        chk("words", words, v.nwords);
        repeat (2) tick();
        chk("writes_drained", exp_q.size(), 0);
    endtask

    initial begin
        vecs[0] = '{8, 64'h0000006F_00000013, 8'h82, 1'b1, 2};
        vecs[1] = '{5, 64'h00000005_04030201, 8'h0F, 1'b1, 2};
        vecs[2] = '{4, 64'h00000000_DDCCBBAA, 8'h00, 1'b0, 1};
        vecs[3] = '{0, 64'h0, 8'h00, 1'b1, 0};
        vecs[4] = '{3, 64'h00000000_0001FFFF, 8'hFF, 1'b1, 1};
        vecs[5] = '{64, 64'h0, 8'h04, 1'b1, 16};
        rst = 1'b1;
        start = 1'b0;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        repeat (2) tick();
        chk("rst_ready", byte_ready, 0);
        chk("rst_we", rom_we, 0);
        chk("rst_addr", rom_addr, 0);
        chk("rst_wdata", rom_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_words", words, 0);
        chk("rst_hold", hold_core, 1);
        rst = 1'b0;
        tick();
        for (int r = 0; r < 2; r++)
            for (int v = 0; v < 6; v++) run_vec(vecs[v], r == 1);

        // oversize length rejected after the fourth length byte
        pulse_start();
        send_len(32'd65);
        chk("ovr_err", err, 1);
        chk("ovr_busy", busy, 0);
        chk("ovr_hold", hold_core, 1);
        chk("ovr_ready", byte_ready, 0);
        byte_valid = 1'b1;
        repeat (3) tick();
        byte_valid = 1'b0;
        chk("ovr_ignored_err", err, 1);
        chk("ovr_words", words, 0);

        // exact capacity is accepted
        pulse_start();
        send_len(32'd64);
        chk("cap_err", err, 0);
        chk("cap_busy", busy, 1);
        chk("cap_ready", byte_ready, 1);

        // restart mid-DATA after one word was written, then an empty load
        pulse_start();
        send_len(32'd8);
        exp_q.push_back({32'd0, 32'h44332211});
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        send_byte(8'h55, 1'b0);
        tick();
        chk("rs_words_before", words, 1);
        pulse_start();
        chk("rs_words_clr", words, 0);
        send_len(32'd0);
        chk("rs_l0_ready", byte_ready, 1);
        send_byte(8'h00, 1'b0);
        chk("rs_done", done, 1);
        chk("rs_words", words, 0);
        chk("rs_hold", hold_core, 0);
        repeat (2) tick();
        chk("rs_drained", exp_q.size(), 0);
        pulse_start();
        chk("rs_done_clr", done, 0);
        chk("rs_busy", busy, 1);

        // asynchronous reset mid-DATA
        pulse_start();
        send_len(32'd8);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_hold", hold_core, 1);
        chk("arst_done", done, 0);
        chk("arst_err", err, 0);
        chk("arst_ready", byte_ready, 0);
        chk("arst_words", words, 0);
        tick();
        rst = 1'b0;
        tick();
        run_vec(vecs[1], 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
